mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory stage directly downstream of the execute ALU. It takes the ALU result
//  (an effective address or a plain result) plus the store data and the load/store
//  op, and runs one data-memory transaction per instruction.
//  - Loads: align and sign/zero-extend the returned data.
//  - Non-memory ops: pass the result through.
//  - Output: one registered entry to writeback, with a valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH          32  datapath width; fixed at 32 (RV32 byte lanes)
//  TIMEOUT_CYCLES 16  request cycles without mem_ack before a bus error; 0 = never time out
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous reset, active-low
//  ex_valid       in   1      execute presents an instruction
//  ex_ready       out  1      stage accepts this cycle
//  ex_alu_result  in   WIDTH  ALU result f (address for ld/st)
//  ex_store_data  in   WIDTH  rs2 value for stores
//  ex_rd          in   5      destination register
//  ex_mem_op      in   2      00 none, 01 load, 10 store, 11 reserved (treated as none)
//  ex_funct3      in   3      size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  mem_req        out  1      request, held until mem_ack
//  mem_we         out  1      1 = write
//  mem_addr       out  WIDTH  word-aligned address ({addr[31:2],2'b00})
//  mem_be         out  4      byte enables
//  mem_wdata      out  WIDTH  lane-replicated store data
//  mem_ack        in   1      transaction complete; mem_rdata valid the same cycle
//  mem_rdata      in   WIDTH  read data
//  wb_valid       out  1      writeback entry valid
//  wb_ready       in   1      writeback consumes entry
//  wb_data        out  WIDTH  result / extended load data
//  wb_rd          out  5      destination register
//  wb_we          out  1      register write enable (0 for stores, errors, rd==0)
//  wb_err         out  1      bus error (timeout) or misalignment trap
// BEHAVIOUR
//  - Reset (async, rst_n low): state IDLE; mem_req, mem_we, wb_valid, wb_we and wb_err = 0;
//    mem_addr, mem_be, mem_wdata, wb_data and wb_rd = 0; timeout counter = 0.
//    Reset mid-transaction drops mem_req immediately; a late mem_ack is ignored.
//  - FSM states:
//    - IDLE: ex_ready = !wb_valid | wb_ready. Accept on ex_valid & ex_ready.
//      Op none goes to IDLE (result registered); op ld/st goes to MEM.
//    - MEM: mem_req = 1. Address, be, wdata and we are registered at accept and held stable.
//      mem_ack goes to IDLE and loads the output entry.
//      Timeout goes to IDLE with wb_err = 1 and wb_we = 0.
//  - Latency, accept to wb_valid:
//    - none: 1 cycle.
//    - ld/st: request asserts on cycle +1; wb_valid asserts the cycle after mem_ack.
//  - Output entry: it is empty whenever the FSM is in MEM. When accept and wb_ready occur in the
//    same cycle, the entry is replaced and wb_valid stays 1. While wb_valid & !wb_ready, all wb_*
//    outputs are stable.
//  - mem_be by addr[1:0]:
//    - B: 4'b0001 << a[1:0].
//    - H: 4'b0011 << {a[1],1'b0}.
//    - W: 4'b1111.
//  - mem_wdata: B = {4{sd[7:0]}}, H = {2{sd[15:0]}}, W = sd.
//  - Load extract: select the byte/half lane by addr[1:0]. B/H are sign-extended, BU/HU
//    zero-extended, W passes through.
//  - Timeout counter: cleared on entering MEM, +1 per MEM cycle without ack. An error fires when
//    the count reaches TIMEOUT_CYCLES. If mem_ack arrives in the same cycle the counter expires,
//    the ack wins.
//  - wb_we = 1 only for none/load with rd != 0 and no error.
// CONFIGURATION
//  - MEM_MISALIGN_TRAP_EN defined: misaligned H (a[0]=1) or W (a[1:0]!=0) issues no request.
//    The entry is produced 1 cycle after accept with wb_err = 1, wb_we = 0, wb_data = address.
//  - Undefined: low address bits are ignored for lane selection (H uses a[1], W uses none).
//    The access proceeds normally and wb_err is only ever set by timeout.
// TESTING
//  1. Pass-through: none op, result=0x00001234, rd=5 -> next cycle wb_valid=1, wb_data=0x00001234,
//     wb_we=1, mem_req never 1.
//  2. LB at 0x00000103, ack 2 cycles later, rdata=0x80000000 -> mem_addr=0x100, be=4'b1000,
//     wb_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
//  3. SH at 0x102, sd=0x0000ABCD -> mem_we=1, be=4'b1100, wdata=0xABCDABCD, wb_we=0.
//     Then hold wb_ready=0 for 3 cycles -> ex_ready=0, all wb_* stable.
//  4. LW with no ack, TIMEOUT_CYCLES=16 -> mem_req high 16 cycles then drops, wb_err=1, wb_we=0.
//     Ack on cycle 16 -> normal completion, no error.
//  5. LW at 0x101:
//     - MEM_MISALIGN_TRAP_EN defined -> no mem_req, wb_err=1, wb_data=0x101.
//     - Undefined -> mem_addr=0x100, be=4'b1111, normal data.
//  6. Assert rst_n low during MEM -> mem_req=0 immediately; ack after release has no effect;
//     back-to-back ALU ops with wb_ready=1 -> one result per cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage that sits right after the execute ALU. Each accepted
//   instruction is either passed straight to writeback (no memory op) or turned
//   into one data-memory transaction (load/store). Load data is lane-selected and
//   sign/zero extended. A single registered entry feeds writeback through a
//   valid/ready handshake.
//
//   Optional feature macro: MEM_MISALIGN_TRAP_EN
//     defined   : misaligned H/W accesses trap without a bus request
//     undefined : low address bits beyond the access size are ignored
//
// Ports
//   clk, rst_n                      clock / async active-low reset
//   ex_valid, ex_ready              execute-side handshake
//   ex_alu_result, ex_store_data    address or result, store data
//   ex_rd, ex_mem_op, ex_funct3     destination, op (00 none/01 ld/10 st/11 none), size/sign
//   mem_req, mem_we, mem_addr       memory request (held until mem_ack)
//   mem_be, mem_wdata               byte enables, lane-replicated store data
//   mem_ack, mem_rdata              completion and read data (same cycle)
//   wb_valid, wb_ready              writeback handshake
//   wb_data, wb_rd, wb_we, wb_err   writeback entry
//
// state | meaning
// IDLE  | no transaction outstanding; may accept from execute
// MEM   | request outstanding; output entry is empty
module mem_access_stage #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [WIDTH-1:0] ex_alu_result,
  input  logic [WIDTH-1:0] ex_store_data,
  input  logic [4:0]       ex_rd,
  input  logic [1:0]       ex_mem_op,
  input  logic [2:0]       ex_funct3,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_we,
  output logic             wb_err
);

  typedef enum logic {IDLE, MEM} state_t;

  localparam int            CW        = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam bit            TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_t          state, state_next;
  logic [CW-1:0]   tmo_cnt;
  logic [2:0]      funct3_q;
  logic [1:0]      lane_q;
  logic [4:0]      rd_q;
  logic            is_load_q;

  logic             accept, is_mem_op, misalign, tmo_fire;
  logic [3:0]       be_calc;
  logic [WIDTH-1:0] wdata_calc, load_data;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ex_ready   = 1'b0;
    mem_req    = 1'b0;
    accept     = 1'b0;
    tmo_fire   = 1'b0;
    is_mem_op  = (ex_mem_op == 2'b01) || (ex_mem_op == 2'b10);
    misalign   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    case (ex_funct3[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = ex_alu_result[0];
      default: misalign = (ex_alu_result[1:0] != 2'b00);
    endcase
`endif
    case (state)
      IDLE: begin
        ex_ready = !wb_valid || wb_ready;
        accept   = ex_valid && ex_ready;
        if (accept && is_mem_op && !misalign) state_next = MEM;
      end
      MEM: begin
        mem_req  = 1'b1;
        // ack wins over an expiry in the same cycle
        tmo_fire = TMO_EN && !mem_ack && ((tmo_cnt + CW'(1)) == TMO_LIMIT);
        if (mem_ack || tmo_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte enables and store-lane replication from the size in funct3[1:0].
  always_comb begin
    case (ex_funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << ex_alu_result[1:0];
        wdata_calc = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {ex_alu_result[1], 1'b0};
        wdata_calc = {2{ex_store_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = ex_store_data;
      end
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    rd_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{(WIDTH-8){rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {{(WIDTH-8){1'b0}}, rd_byte};
      3'b001:  load_data = {{(WIDTH-16){rd_half[15]}}, rd_half};
      3'b101:  load_data = {{(WIDTH-16){1'b0}}, rd_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      tmo_cnt   <= '0;
      funct3_q  <= '0;
      lane_q    <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      wb_we     <= 1'b0;
      wb_err    <= 1'b0;
    end else if (accept) begin
      if (is_mem_op && !misalign) begin
        mem_addr  <= {ex_alu_result[WIDTH-1:2], 2'b00};
        mem_be    <= be_calc;
        mem_wdata <= wdata_calc;
        mem_we    <= (ex_mem_op == 2'b10);
        funct3_q  <= ex_funct3;
        lane_q    <= ex_alu_result[1:0];
        rd_q      <= ex_rd;
        is_load_q <= (ex_mem_op == 2'b01);
        tmo_cnt   <= '0;
        wb_valid  <= 1'b0;
      end else begin
        // Non-memory op, or a trapped misaligned access carrying its address.
        wb_valid <= 1'b1;
        wb_data  <= ex_alu_result;
        wb_rd    <= ex_rd;
        wb_we    <= !is_mem_op && (ex_rd != 5'd0);
        wb_err   <= is_mem_op;
      end
    end else if (state == MEM) begin
      if (mem_ack) begin
        wb_valid <= 1'b1;
        wb_data  <= is_load_q ? load_data : '0;
        wb_rd    <= rd_q;
        wb_we    <= is_load_q && (rd_q != 5'd0);
        wb_err   <= 1'b0;
      end else if (tmo_fire) begin
        wb_valid <= 1'b1;
        wb_data  <= '0;
        wb_rd    <= rd_q;
        wb_we    <= 1'b0;
        wb_err   <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic [1:0]  ex_mem_op = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we, wb_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_mem_op(ex_mem_op), .ex_funct3(ex_funct3),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .wb_err(wb_err)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    int          delay;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        mwe;
    logic        chkd;
    logic [31:0] wbd;
    logic        wbwe;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    ex_mem_op     = v.op;
    ex_funct3     = v.f3;
    ex_alu_result = v.alu;
    ex_store_data = v.sd;
    ex_rd         = v.rd;
    ex_valid      = 1'b1;
    chk($sformatf("v%0d_ex_ready", idx), 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (v.req) begin
      chk($sformatf("v%0d_mem_req", idx), 32'(mem_req), 32'd1);
      chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
      chk($sformatf("v%0d_mem_be", idx), 32'(mem_be), 32'(v.be));
      chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
      chk($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(v.mwe));
      chk($sformatf("v%0d_wb_empty", idx), 32'(wb_valid), 32'd0);
      for (int i = 0; i < v.delay; i++) begin
        @(posedge clk); #1;
      end
      chk($sformatf("v%0d_req_held", idx), 32'(mem_req), 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    chk($sformatf("v%0d_req_low", idx), 32'(mem_req), 32'd0);
    chk($sformatf("v%0d_wb_valid", idx), 32'(wb_valid), 32'd1);
    chk($sformatf("v%0d_wb_err", idx), 32'(wb_err), 32'(v.err));
    chk($sformatf("v%0d_wb_we", idx), 32'(wb_we), 32'(v.wbwe));
    chk($sformatf("v%0d_wb_rd", idx), 32'(wb_rd), 32'(v.rd));
    if (v.chkd) chk($sformatf("v%0d_wb_data", idx), wb_data, v.wbd);
  endtask

  initial begin
    int cyc;
    // op f3 alu sd rd delay rdata | req addr be wdata mwe chkd wbd wbwe err
    vecs.push_back('{2'b00, 3'b010, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_1234, 1'b1, 1'b0});
    vecs.push_back('{2'b01, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 2, 32'h8000_0000,
                     1'b1, 32'h0000_0100, 4'b1000, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0});
    vecs.push_back('{2'b01, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 2, 32'h8000_0000,
                     1'b1, 32'h0000_0100, 4'b1000, 32'h0, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b0});
    vecs.push_back('{2'b10, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd3, 1, 32'h0,
                     1'b1, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
`ifdef MEM_MISALIGN_TRAP_EN
    vecs.push_back('{2'b01, 3'b010, 32'h0000_0101, 32'h1122_3344, 5'd8, 0, 32'hCAFE_BABE,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0101, 1'b0, 1'b1});
`else
    vecs.push_back('{2'b01, 3'b010, 32'h0000_0101, 32'h1122_3344, 5'd8, 0, 32'hCAFE_BABE,
                     1'b1, 32'h0000_0100, 4'b1111, 32'h1122_3344, 1'b0, 1'b1, 32'hCAFE_BABE, 1'b1, 1'b0});
`endif
    vecs.push_back('{2'b01, 3'b001, 32'h0000_0206, 32'h0, 5'd9, 0, 32'h8001_0000,
                     1'b1, 32'h0000_0204, 4'b1100, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0});
    vecs.push_back('{2'b01, 3'b101, 32'h0000_0206, 32'h0, 5'd9, 0, 32'h8001_0000,
                     1'b1, 32'h0000_0204, 4'b1100, 32'h0, 1'b0, 1'b1, 32'h0000_8001, 1'b1, 1'b0});
    vecs.push_back('{2'b10, 3'b000, 32'h0000_0301, 32'h0000_00A5, 5'd2, 0, 32'h0,
                     1'b1, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{2'b10, 3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 5'd2, 3, 32'h0,
                     1'b1, 32'h0000_0400, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{2'b00, 3'b000, 32'h0000_0055, 32'h0, 5'd0, 0, 32'h0,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0055, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 3'b000, 32'h0000_0077, 32'h0, 5'd4, 0, 32'h0,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0077, 1'b1, 1'b0});
    // ack arrives on the 16th request cycle, the same cycle the timer would expire
    vecs.push_back('{2'b01, 3'b010, 32'h0000_0500, 32'h0, 5'd1, 15, 32'h1234_5678,
                     1'b1, 32'h0000_0500, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0});
    vecs.push_back('{2'b01, 3'b000, 32'h0000_0000, 32'h0, 5'd0, 0, 32'h0000_007F,
                     1'b1, 32'h0000_0000, 4'b0001, 32'h0, 1'b0, 1'b1, 32'h0000_007F, 1'b0, 1'b0});
    vecs.push_back('{2'b01, 3'b001, 32'h0000_0600, 32'h0, 5'd10, 0, 32'h0000_8000,
                     1'b1, 32'h0000_0600, 4'b0011, 32'h0, 1'b0, 1'b1, 32'hFFFF_8000, 1'b1, 1'b0});

    // reset state
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Store completes while writeback is stalled; entry must hold, then be replaced.
    @(posedge clk); #1;
    wb_ready = 1'b0;
    ex_mem_op = 2'b10; ex_funct3 = 3'b001; ex_alu_result = 32'h102;
    ex_store_data = 32'h0000_ABCD; ex_rd = 5'd3; ex_valid = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b1;
    ex_mem_op = 2'b00; ex_alu_result = 32'h99; ex_rd = 5'd6;
    chk("stall_ex_ready_mem", 32'(ex_ready), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ex_ready", 32'(ex_ready), 32'd0);
      chk("stall_wb_valid", 32'(wb_valid), 32'd1);
      chk("stall_wb_rd", 32'(wb_rd), 32'd3);
      chk("stall_wb_we", 32'(wb_we), 32'd0);
      chk("stall_wb_err", 32'(wb_err), 32'd0);
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    #1 chk("stall_release_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("replace_wb_valid", 32'(wb_valid), 32'd1);
    chk("replace_wb_data", wb_data, 32'h99);
    chk("replace_wb_rd", 32'(wb_rd), 32'd6);
    chk("replace_wb_we", 32'(wb_we), 32'd1);

    // Timeout: no ack at all
    @(posedge clk); #1;
    ex_mem_op = 2'b01; ex_funct3 = 3'b010; ex_alu_result = 32'h700; ex_rd = 5'd11; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    cyc = 0;
    while (mem_req && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk("tmo_req_cycles", 32'(cyc), 32'd16);
    chk("tmo_req_low", 32'(mem_req), 32'd0);
    chk("tmo_wb_valid", 32'(wb_valid), 32'd1);
    chk("tmo_wb_err", 32'(wb_err), 32'd1);
    chk("tmo_wb_we", 32'(wb_we), 32'd0);

    // Reset in the middle of a transaction
    ex_mem_op = 2'b01; ex_funct3 = 3'b010; ex_alu_result = 32'h800; ex_rd = 5'd12; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    chk("mrst_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_req_drop", 32'(mem_req), 32'd0);
    chk("mrst_wb_valid", 32'(wb_valid), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("late_ack_req", 32'(mem_req), 32'd0);

    // Back-to-back ALU ops, one result per cycle
    ex_mem_op = 2'b00; ex_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex_alu_result = 32'hA000 + 32'(i);
      ex_rd = 5'(i + 1);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("b2b%0d_wb_data", i), wb_data, 32'hA000 + 32'(i));
      chk($sformatf("b2b%0d_req", i), 32'(mem_req), 32'd0);
    end
    ex_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_wb_valid", 32'(wb_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
